// File: rtl/axi_ddr_pkg.sv
// Shared constants and FSM state types for the AXI RAM slave.
package axi_ddr_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [2:0] SIZE_8B     = 3'b011;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  typedef enum logic {
    R_IDLE = 1'b0,
    R_DATA = 1'b1
  } r_state_e;

endpackage

// File: rtl/ram_dp_bwe.sv
// Simple dual-port RAM: byte-enabled write port, synchronous read port whose
// output register holds its value while the read enable is low.
module ram_dp_bwe #(
  parameter int DEPTH = 1024,
  parameter int IDX_W = 10,
  parameter int DW    = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               wr_en,
  input  logic [IDX_W-1:0]   wr_addr,
  input  logic [DW/8-1:0]    wr_be,
  input  logic [DW-1:0]      wr_data,
  input  logic               rd_en,
  input  logic [IDX_W-1:0]   rd_addr,
  output logic [DW-1:0]      rd_data
);

  logic [DW-1:0] mem_q [0:DEPTH-1];
  logic [DW-1:0] rd_data_q;

  // Byte-lane writes; array contents are never reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int b = 0; b < DW / 8; b++) begin
        if (wr_be[b]) begin
          mem_q[wr_addr][b*8 +: 8] <= wr_data[b*8 +: 8];
        end
      end
    end
  end

  // Read register samples the pre-write contents, so a same-cycle collision returns old data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_en) begin
      rd_data_q <= mem_q[rd_addr];
    end else begin
      rd_data_q <= rd_data_q;
    end
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/axi_ram_slave.sv
// AXI4 slave backed by on-chip RAM; independent INCR read and write channels.
module axi_ram_slave
  import axi_ddr_pkg::*;
#(
  parameter int ADDR_WIDTH = 30,
  parameter int DATA_WIDTH = 64,
  parameter int ID_WIDTH   = 4,
  parameter int MEM_DEPTH  = 1024
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [ID_WIDTH-1:0]     s_axi_awid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_awaddr,
  input  logic [7:0]              s_axi_awlen,
  input  logic [2:0]              s_axi_awsize,
  input  logic [1:0]              s_axi_awburst,
  input  logic                    s_axi_awvalid,
  output logic                    s_axi_awready,
  input  logic [DATA_WIDTH-1:0]   s_axi_wdata,
  input  logic [DATA_WIDTH/8-1:0] s_axi_wstrb,
  input  logic                    s_axi_wlast,
  input  logic                    s_axi_wvalid,
  output logic                    s_axi_wready,
  output logic [ID_WIDTH-1:0]     s_axi_bid,
  output logic [1:0]              s_axi_bresp,
  output logic                    s_axi_bvalid,
  input  logic                    s_axi_bready,
  input  logic [ID_WIDTH-1:0]     s_axi_arid,
  input  logic [ADDR_WIDTH-1:0]   s_axi_araddr,
  input  logic [7:0]              s_axi_arlen,
  input  logic [2:0]              s_axi_arsize,
  input  logic [1:0]              s_axi_arburst,
  input  logic                    s_axi_arvalid,
  output logic                    s_axi_arready,
  output logic [DATA_WIDTH-1:0]   s_axi_rdata,
  output logic [1:0]              s_axi_rresp,
  output logic                    s_axi_rlast,
  output logic                    s_axi_rvalid,
  output logic [ID_WIDTH-1:0]     s_axi_rid,
  input  logic                    s_axi_rready
);

  localparam int IDX_W = $clog2(MEM_DEPTH);

  // Write channel state
  w_state_e            w_state_q, w_state_d;
  logic [IDX_W-1:0]    widx_q, widx_d;
  logic [7:0]          wbeat_q, wbeat_d;
  logic [7:0]          awlen_q, awlen_d;
  logic                werr_q, werr_d;
  logic [ID_WIDTH-1:0] bid_q, bid_d;
  logic [1:0]          bresp_q, bresp_d;
  logic                ram_we_s;

  // Read channel state
  r_state_e            r_state_q, r_state_d;
  logic [IDX_W-1:0]    ridx_q, ridx_d;
  logic [7:0]          rbeat_q, rbeat_d;
  logic [7:0]          arlen_q, arlen_d;
  logic [ID_WIDTH-1:0] rid_q, rid_d;
  logic                rlast_q, rlast_d;
  logic                rd_en_s;
  logic [IDX_W-1:0]    rd_addr_s;

  // Size, burst type and address bits outside the word index carry no meaning here.
  logic unused_s;
  assign unused_s = ^{s_axi_awsize, s_axi_awburst, s_axi_arsize, s_axi_arburst,
                      s_axi_awaddr, s_axi_araddr};

  // Write FSM next state: capture AW, accept awlen+1 beats, track wlast placement.
  always_comb begin
    w_state_d = w_state_q;
    widx_d    = widx_q;
    wbeat_d   = wbeat_q;
    awlen_d   = awlen_q;
    werr_d    = werr_q;
    bid_d     = bid_q;
    bresp_d   = bresp_q;
    ram_we_s  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        if (s_axi_awvalid) begin
          bid_d     = s_axi_awid;
          widx_d    = s_axi_awaddr[IDX_W+2:3];
          awlen_d   = s_axi_awlen;
          wbeat_d   = 8'd0;
          werr_d    = 1'b0;
          w_state_d = W_DATA;
        end else begin
          w_state_d = W_IDLE;
        end
      end
      W_DATA: begin
        if (s_axi_wvalid) begin
          ram_we_s = 1'b1;
          widx_d   = widx_q + IDX_W'(1);
          wbeat_d  = wbeat_q + 8'd1;
          if (wbeat_q == awlen_q) begin
            bresp_d   = (werr_q || !s_axi_wlast) ? RESP_SLVERR : RESP_OKAY;
            w_state_d = W_RESP;
          end else if (s_axi_wlast) begin
            werr_d = 1'b1;
          end else begin
            werr_d = werr_q;
          end
        end else begin
          w_state_d = W_DATA;
        end
      end
      W_RESP: begin
        if (s_axi_bready) begin
          w_state_d = W_IDLE;
        end else begin
          w_state_d = W_RESP;
        end
      end
      default: begin
        w_state_d = W_IDLE;
      end
    endcase
  end

  // Write FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      widx_q    <= '0;
      wbeat_q   <= 8'd0;
      awlen_q   <= 8'd0;
      werr_q    <= 1'b0;
      bid_q     <= '0;
      bresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      widx_q    <= widx_d;
      wbeat_q   <= wbeat_d;
      awlen_q   <= awlen_d;
      werr_q    <= werr_d;
      bid_q     <= bid_d;
      bresp_q   <= bresp_d;
    end
  end

  // Read FSM next state: prefetch beat 0 on AR, fetch the next word on each non-final handshake.
  always_comb begin
    r_state_d = r_state_q;
    ridx_d    = ridx_q;
    rbeat_d   = rbeat_q;
    arlen_d   = arlen_q;
    rid_d     = rid_q;
    rlast_d   = rlast_q;
    rd_en_s   = 1'b0;
    rd_addr_s = ridx_q;
    case (r_state_q)
      R_IDLE: begin
        if (s_axi_arvalid) begin
          rd_en_s   = 1'b1;
          rd_addr_s = s_axi_araddr[IDX_W+2:3];
          ridx_d    = s_axi_araddr[IDX_W+2:3];
          rbeat_d   = 8'd0;
          arlen_d   = s_axi_arlen;
          rid_d     = s_axi_arid;
          rlast_d   = (s_axi_arlen == 8'd0);
          r_state_d = R_DATA;
        end else begin
          r_state_d = R_IDLE;
        end
      end
      R_DATA: begin
        if (s_axi_rready) begin
          if (rlast_q) begin
            rlast_d   = 1'b0;
            r_state_d = R_IDLE;
          end else begin
            rd_en_s   = 1'b1;
            rd_addr_s = ridx_q + IDX_W'(1);
            ridx_d    = ridx_q + IDX_W'(1);
            rbeat_d   = rbeat_q + 8'd1;
            rlast_d   = ((rbeat_q + 8'd1) == arlen_q);
          end
        end else begin
          r_state_d = R_DATA;
        end
      end
      default: begin
        r_state_d = R_IDLE;
      end
    endcase
  end

  // Read FSM registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      ridx_q    <= '0;
      rbeat_q   <= 8'd0;
      arlen_q   <= 8'd0;
      rid_q     <= '0;
      rlast_q   <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      ridx_q    <= ridx_d;
      rbeat_q   <= rbeat_d;
      arlen_q   <= arlen_d;
      rid_q     <= rid_d;
      rlast_q   <= rlast_d;
    end
  end

  ram_dp_bwe #(
    .DEPTH (MEM_DEPTH),
    .IDX_W (IDX_W),
    .DW    (DATA_WIDTH)
  ) u_ram (
    .clk     (clk),
    .rst_n   (rst_n),
    .wr_en   (ram_we_s),
    .wr_addr (widx_q),
    .wr_be   (s_axi_wstrb),
    .wr_data (s_axi_wdata),
    .rd_en   (rd_en_s),
    .rd_addr (rd_addr_s),
    .rd_data (s_axi_rdata)
  );

  assign s_axi_awready = (w_state_q == W_IDLE);
  assign s_axi_wready  = (w_state_q == W_DATA);
  assign s_axi_bvalid  = (w_state_q == W_RESP);
  assign s_axi_bid     = bid_q;
  assign s_axi_bresp   = bresp_q;
  assign s_axi_arready = (r_state_q == R_IDLE);
  assign s_axi_rvalid  = (r_state_q == R_DATA);
  assign s_axi_rid     = rid_q;
  assign s_axi_rlast   = rlast_q;
  assign s_axi_rresp   = RESP_OKAY;

endmodule

// File: tb/tb_axi_ram_slave.sv
// Directed testbench for axi_ram_slave.
module tb_axi_ram_slave;
  import axi_ddr_pkg::*;

  localparam int AW = 30;
  localparam int DW = 64;
  localparam int IW = 4;
  localparam int WAIT_MAX = 50;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [IW-1:0] awid = '0;
  logic [AW-1:0] awaddr = '0;
  logic [7:0]    awlen = 8'd0;
  logic [2:0]    awsize = 3'd0;
  logic [1:0]    awburst = 2'd0;
  logic          awvalid = 1'b0;
  logic          awready;
  logic [DW-1:0] wdata = '0;
  logic [7:0]    wstrb = 8'd0;
  logic          wlast = 1'b0;
  logic          wvalid = 1'b0;
  logic          wready;
  logic [IW-1:0] bid;
  logic [1:0]    bresp;
  logic          bvalid;
  logic          bready = 1'b0;
  logic [IW-1:0] arid = '0;
  logic [AW-1:0] araddr = '0;
  logic [7:0]    arlen = 8'd0;
  logic [2:0]    arsize = 3'd0;
  logic [1:0]    arburst = 2'd0;
  logic          arvalid = 1'b0;
  logic          arready;
  logic [DW-1:0] rdata;
  logic [1:0]    rresp;
  logic          rlast;
  logic          rvalid;
  logic [IW-1:0] rid;
  logic          rready = 1'b0;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] wbuf_data [0:255];
  logic [7:0]    wbuf_strb [0:255];
  logic          wbuf_last [0:255];
  logic [DW-1:0] rbuf_data [0:255];
  logic          rbuf_last [0:255];
  logic [IW-1:0] rbuf_id;

  always #5 clk = ~clk;

  axi_ram_slave dut (
    .clk(clk), .rst_n(rst_n),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen),
    .s_axi_awsize(awsize), .s_axi_awburst(awburst),
    .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast),
    .s_axi_wvalid(wvalid), .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen),
    .s_axi_arsize(arsize), .s_axi_arburst(arburst),
    .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rid(rid), .s_axi_rready(rready)
  );

  task automatic bound_fail(input string what);
    checks++;
    errors++;
    $display("FAIL timeout_%s: handshake not seen, required within %0d cycles", what, WAIT_MAX);
  endtask

  task automatic fill_incr(input logic [DW-1:0] base, input int len);
    for (int k = 0; k <= len; k++) begin
      wbuf_data[k] = base + DW'(k);
      wbuf_strb[k] = 8'hFF;
      wbuf_last[k] = (k == len);
    end
  endtask

  task automatic send_aw(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    int n;
    n = 0;
    awid = id; awaddr = addr; awlen = len; awsize = SIZE_8B; awburst = BURST_INCR; awvalid = 1'b1;
    @(negedge clk);
    while (!awready && n < WAIT_MAX) begin @(negedge clk); n++; end
    if (n >= WAIT_MAX) bound_fail("aw");
    @(posedge clk); #1;
    awvalid = 1'b0;
  endtask

  task automatic send_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len);
    int n;
    n = 0;
    arid = id; araddr = addr; arlen = len; arsize = SIZE_8B; arburst = BURST_INCR; arvalid = 1'b1;
    @(negedge clk);
    while (!arready && n < WAIT_MAX) begin @(negedge clk); n++; end
    if (n >= WAIT_MAX) bound_fail("ar");
    @(posedge clk); #1;
    arvalid = 1'b0;
  endtask

  task automatic send_w(input logic [DW-1:0] d, input logic [7:0] s, input logic l, output int waits);
    wdata = d; wstrb = s; wlast = l; wvalid = 1'b1; waits = 0;
    @(negedge clk);
    while (!wready && waits < WAIT_MAX) begin @(negedge clk); waits++; end
    if (waits >= WAIT_MAX) bound_fail("w");
    @(posedge clk); #1;
    wvalid = 1'b0; wlast = 1'b0;
  endtask

  task automatic axi_write(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                           output logic [1:0] resp, output logic [IW-1:0] got_id,
                           output int waits, output logic b_imm);
    int n;
    waits = 0;
    send_aw(id, addr, len);
    for (int k = 0; k <= int'(len); k++) begin
      send_w(wbuf_data[k], wbuf_strb[k], wbuf_last[k], n);
      waits += n;
    end
    @(negedge clk);
    b_imm = bvalid;
    bready = 1'b1;
    n = 0;
    while (!bvalid && n < WAIT_MAX) begin @(negedge clk); n++; end
    if (n >= WAIT_MAX) bound_fail("b");
    resp = bresp;
    got_id = bid;
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic axi_read(input logic [IW-1:0] id, input logic [AW-1:0] addr, input logic [7:0] len,
                          input bit toggle, output logic r_imm, output int waits, output int unstable);
    logic [DW-1:0] held;
    int n;
    waits = 0;
    unstable = 0;
    send_ar(id, addr, len);
    @(negedge clk);
    r_imm = rvalid;
    for (int k = 0; k <= int'(len); k++) begin
      if (toggle) begin
        rready = 1'b0;
        held = rdata;
        @(posedge clk); #1;
        @(negedge clk);
        if (rdata !== held || !rvalid) unstable++;
      end
      rready = 1'b1;
      n = 0;
      while (!rvalid && n < WAIT_MAX) begin @(negedge clk); n++; end
      if (n >= WAIT_MAX) bound_fail("r");
      waits += n;
      rbuf_data[k] = rdata;
      rbuf_last[k] = rlast;
      rbuf_id = rid;
      @(posedge clk); #1;
      if (k < int'(len)) @(negedge clk);
    end
    rready = 1'b0;
  endtask

  task automatic test_reset;
    #12;
    checks++;
    if ({awready, arready, wready, bvalid, rvalid, rlast} !== 6'b110000) begin
      errors++;
      $display("FAIL reset_ctrl: got %b, required 110000", {awready, arready, wready, bvalid, rvalid, rlast});
    end
    checks++;
    if ({bresp, rresp, bid, rid} !== 12'h000) begin
      errors++;
      $display("FAIL reset_ids: got %h, required 000", {bresp, rresp, bid, rid});
    end
    checks++;
    if (rdata !== 64'h0) begin
      errors++;
      $display("FAIL reset_rdata: got %h, required 0", rdata);
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_single;
    logic [1:0] resp; logic [IW-1:0] gid; int waits; int unst; logic imm;
    wbuf_data[0] = 64'h1122334455667788; wbuf_strb[0] = 8'hFF; wbuf_last[0] = 1'b1;
    axi_write(4'h5, 30'h08, 8'd0, resp, gid, waits, imm);
    checks++;
    if (waits !== 0 || imm !== 1'b1) begin
      errors++;
      $display("FAIL single_w_timing: got waits=%0d bvalid_next=%b, required 0 and 1", waits, imm);
    end
    checks++;
    if (resp !== RESP_OKAY || gid !== 4'h5) begin
      errors++;
      $display("FAIL single_b: got bresp=%b bid=%h, required 00 and 5", resp, gid);
    end
    axi_read(4'hA, 30'h08, 8'd0, 1'b0, imm, waits, unst);
    checks++;
    if (imm !== 1'b1 || waits !== 0) begin
      errors++;
      $display("FAIL single_r_timing: got rvalid_next=%b waits=%0d, required 1 and 0", imm, waits);
    end
    checks++;
    if (rbuf_data[0] !== 64'h1122334455667788 || rbuf_last[0] !== 1'b1 || rbuf_id !== 4'hA) begin
      errors++;
      $display("FAIL single_r: got %h last=%b id=%h, required 1122334455667788 1 a",
               rbuf_data[0], rbuf_last[0], rbuf_id);
    end
  endtask

  task automatic test_burst_backpressure;
    logic [1:0] resp; logic [IW-1:0] gid; int waits; int unst; logic imm;
    fill_incr(64'd0, 15);
    axi_write(4'h1, 30'h100, 8'd15, resp, gid, waits, imm);
    checks++;
    if (resp !== RESP_OKAY || waits !== 0) begin
      errors++;
      $display("FAIL burst_w: got bresp=%b waits=%0d, required 00 and 0", resp, waits);
    end
    axi_read(4'h2, 30'h100, 8'd15, 1'b1, imm, waits, unst);
    checks++;
    if (unst !== 0) begin
      errors++;
      $display("FAIL burst_stall: got %0d unstable stalls, required 0", unst);
    end
    for (int k = 0; k < 16; k++) begin
      checks++;
      if (rbuf_data[k] !== 64'(k) || rbuf_last[k] !== (k == 15)) begin
        errors++;
        $display("FAIL burst_beat%0d: got %h last=%b, required %h last=%b",
                 k, rbuf_data[k], rbuf_last[k], 64'(k), (k == 15));
      end
    end
  endtask

  task automatic test_strobes;
    logic [1:0] resp; logic [IW-1:0] gid; int waits; int unst; logic imm;
    wbuf_data[0] = 64'hFFFF_FFFF_FFFF_FFFF; wbuf_strb[0] = 8'hFF; wbuf_last[0] = 1'b1;
    axi_write(4'h3, 30'h200, 8'd0, resp, gid, waits, imm);
    wbuf_data[0] = 64'h0; wbuf_strb[0] = 8'h0F; wbuf_last[0] = 1'b1;
    axi_write(4'h3, 30'h200, 8'd0, resp, gid, waits, imm);
    axi_read(4'h3, 30'h200, 8'd0, 1'b0, imm, waits, unst);
    checks++;
    if (rbuf_data[0] !== 64'hFFFF_FFFF_0000_0000) begin
      errors++;
      $display("FAIL strobe: got %h, required ffffffff00000000", rbuf_data[0]);
    end
  endtask

  task automatic test_wrap;
    logic [1:0] resp; logic [IW-1:0] gid; int waits; int unst; logic imm;
    fill_incr(64'hC0DE_0000, 3);
    axi_write(4'h4, 30'h1FF0, 8'd3, resp, gid, waits, imm);
    axi_read(4'h4, 30'h1FF0, 8'd1, 1'b0, imm, waits, unst);
    checks++;
    if (rbuf_data[0] !== 64'hC0DE_0000 || rbuf_data[1] !== 64'hC0DE_0001) begin
      errors++;
      $display("FAIL wrap_top: got %h %h, required c0de0000 c0de0001", rbuf_data[0], rbuf_data[1]);
    end
    axi_read(4'h4, 30'h0, 8'd1, 1'b0, imm, waits, unst);
    checks++;
    if (rbuf_data[0] !== 64'hC0DE_0002 || rbuf_data[1] !== 64'hC0DE_0003) begin
      errors++;
      $display("FAIL wrap_low: got %h %h, required c0de0002 c0de0003", rbuf_data[0], rbuf_data[1]);
    end
    axi_read(4'h4, 30'h1FF8, 8'd1, 1'b0, imm, waits, unst);
    checks++;
    if (rbuf_data[0] !== 64'hC0DE_0001 || rbuf_data[1] !== 64'hC0DE_0002 || waits !== 0) begin
      errors++;
      $display("FAIL wrap_read: got %h %h waits=%0d, required c0de0001 c0de0002 0",
               rbuf_data[0], rbuf_data[1], waits);
    end
  endtask

  task automatic test_wlast_error;
    logic [1:0] resp; logic [IW-1:0] gid; int waits; int unst; logic imm;
    fill_incr(64'hE000, 3);
    wbuf_last[1] = 1'b1;
    axi_write(4'h6, 30'h300, 8'd3, resp, gid, waits, imm);
    checks++;
    if (resp !== RESP_SLVERR || gid !== 4'h6 || waits !== 0) begin
      errors++;
      $display("FAIL wlast_early: got bresp=%b bid=%h waits=%0d, required 10 6 0", resp, gid, waits);
    end
    axi_read(4'h6, 30'h300, 8'd3, 1'b0, imm, waits, unst);
    checks++;
    if (rbuf_data[2] !== 64'hE002 || rbuf_data[3] !== 64'hE003) begin
      errors++;
      $display("FAIL wlast_early_data: got %h %h, required e002 e003", rbuf_data[2], rbuf_data[3]);
    end
    fill_incr(64'hE100, 3);
    wbuf_last[3] = 1'b0;
    axi_write(4'h7, 30'h340, 8'd3, resp, gid, waits, imm);
    checks++;
    if (resp !== RESP_SLVERR) begin
      errors++;
      $display("FAIL wlast_missing: got bresp=%b, required 10", resp);
    end
  endtask

  task automatic test_back_to_back;
    logic [1:0] resp; logic [IW-1:0] gid; int waits; int unst; logic imm;
    fill_incr(64'h7700, 0);
    axi_write(4'h8, 30'h500, 8'd0, resp, gid, waits, imm);
    checks++;
    if (awready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_awready: got %b, required 1", awready);
    end
    axi_read(4'h8, 30'h100, 8'd2, 1'b0, imm, waits, unst);
    checks++;
    if (arready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_arready: got %b, required 1", arready);
    end
    axi_read(4'h9, 30'h500, 8'd0, 1'b0, imm, waits, unst);
    checks++;
    if (rbuf_data[0] !== 64'h7700 || imm !== 1'b1) begin
      errors++;
      $display("FAIL b2b_read: got %h rvalid_next=%b, required 7700 1", rbuf_data[0], imm);
    end
  endtask

  task automatic test_concurrent;
    logic [1:0] resp; logic [IW-1:0] gid; int wwaits; int rwaits; int unst; logic bimm; logic rimm;
    fill_incr(64'hA000, 7);
    axi_write(4'h1, 30'h600, 8'd7, resp, gid, wwaits, bimm);
    fill_incr(64'hB000, 7);
    fork
      axi_write(4'hB, 30'h700, 8'd7, resp, gid, wwaits, bimm);
      axi_read(4'hC, 30'h600, 8'd7, 1'b0, rimm, rwaits, unst);
    join
    checks++;
    if (resp !== RESP_OKAY || gid !== 4'hB || wwaits !== 0) begin
      errors++;
      $display("FAIL conc_w: got bresp=%b bid=%h waits=%0d, required 00 b 0", resp, gid, wwaits);
    end
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (rbuf_data[k] !== (64'hA000 + 64'(k))) begin
        errors++;
        $display("FAIL conc_r%0d: got %h, required %h", k, rbuf_data[k], 64'hA000 + 64'(k));
      end
    end
    axi_read(4'hC, 30'h700, 8'd7, 1'b0, rimm, rwaits, unst);
    checks++;
    if (rbuf_data[0] !== 64'hB000 || rbuf_data[7] !== 64'hB007) begin
      errors++;
      $display("FAIL conc_wdata: got %h %h, required b000 b007", rbuf_data[0], rbuf_data[7]);
    end
  endtask

  task automatic test_reset_midburst;
    logic [1:0] resp; logic [IW-1:0] gid; int waits; int unst; logic imm;
    send_aw(4'h2, 30'h410, 8'd0);
    send_w(64'h5A5A, 8'hFF, 1'b1, waits);
    send_ar(4'h3, 30'h100, 8'd15);
    @(negedge clk);
    checks++;
    if (bvalid !== 1'b1 || rvalid !== 1'b1) begin
      errors++;
      $display("FAIL rst_pre: got bvalid=%b rvalid=%b, required 1 1", bvalid, rvalid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({bvalid, rvalid, rlast, awready, arready, wready} !== 6'b000110) begin
      errors++;
      $display("FAIL rst_mid1: got %b, required 000110", {bvalid, rvalid, rlast, awready, arready, wready});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    send_aw(4'h2, 30'h400, 8'd3);
    send_w(64'hA0, 8'hFF, 1'b0, waits);
    send_w(64'hA1, 8'hFF, 1'b0, waits);
    rst_n = 1'b0;
    #1;
    checks++;
    if ({wready, awready, bvalid} !== 3'b010) begin
      errors++;
      $display("FAIL rst_mid2: got %b, required 010", {wready, awready, bvalid});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    axi_read(4'h5, 30'h400, 8'd2, 1'b0, imm, waits, unst);
    checks++;
    if (rbuf_data[0] !== 64'hA0 || rbuf_data[1] !== 64'hA1 || rbuf_data[2] !== 64'h5A5A) begin
      errors++;
      $display("FAIL rst_kept: got %h %h %h, required a0 a1 5a5a", rbuf_data[0], rbuf_data[1], rbuf_data[2]);
    end
    fill_incr(64'hD00, 1);
    axi_write(4'hE, 30'h420, 8'd1, resp, gid, waits, imm);
    checks++;
    if (resp !== RESP_OKAY || gid !== 4'hE || imm !== 1'b1) begin
      errors++;
      $display("FAIL rst_after_w: got bresp=%b bid=%h bvalid_next=%b, required 00 e 1", resp, gid, imm);
    end
    axi_read(4'hF, 30'h420, 8'd1, 1'b0, imm, waits, unst);
    checks++;
    if (rbuf_data[0] !== 64'hD00 || rbuf_data[1] !== 64'hD01 || rbuf_last[1] !== 1'b1 || rbuf_id !== 4'hF) begin
      errors++;
      $display("FAIL rst_after_r: got %h %h last=%b id=%h, required d00 d01 1 f",
               rbuf_data[0], rbuf_data[1], rbuf_last[1], rbuf_id);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst_backpressure();
    test_strobes();
    test_wrap();
    test_wlast_error();
    test_back_to_back();
    test_concurrent();
    test_reset_midburst();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
